// File: rtl/mac_seq_if.sv
// Command, operand-memory and completion signals of the MAC sequencer.
// perf_cycles exists only when MAC_SEQ_PERF_EN is defined.
interface mac_seq_if #(
  parameter int AW = 8
);
  logic          start;
  logic [AW:0]   k_len;
  logic          ready;
  logic          err_zero;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mac_rst;
  logic          mac_en;
  logic          rescale;
  logic          done_valid;
  logic          done_ready;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  modport master (
    output start, k_len, done_ready,
    input  ready, err_zero, mem_rd, mem_addr, mac_rst, mac_en, rescale, done_valid
`ifdef MAC_SEQ_PERF_EN
    , input perf_cycles
`endif
  );

  modport slave (
    input  start, k_len, done_ready,
    output ready, err_zero, mem_rd, mem_addr, mac_rst, mac_en, rescale, done_valid
`ifdef MAC_SEQ_PERF_EN
    , output perf_cycles
`endif
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one dot-product pass of the int8 MAC/quantize array.
// Optional saturating pass-latency counter enabled by MAC_SEQ_PERF_EN.
module mac_seq_ctrl #(
  parameter int AW          = 8,
  parameter int MEM_LAT     = 1,
  parameter int ACC_LAT     = 1,
  parameter int RESCALE_CYC = 2,
  parameter int QUANT_LAT   = 4
) (
  input  logic     clk,
  input  logic     main_rst_n,
  mac_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RESCALE = 3'd4,
    ST_QWAIT   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Phase timers are loaded with length-1 and count down to zero.
  localparam logic [7:0]    DRAIN_LOAD   = 8'(MEM_LAT + ACC_LAT - 1);
  localparam logic [7:0]    RESCALE_LOAD = 8'(RESCALE_CYC - 1);
  localparam logic [7:0]    QUANT_LOAD   = (QUANT_LAT == 0) ? 8'd0 : 8'(QUANT_LAT - 1);
  localparam logic [AW-1:0] ONE_AW       = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_r, state_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic [AW-1:0] k_last_r, k_last_nxt_s;
  logic [7:0]    tmr_r, tmr_nxt_s;
  logic          accept_s, err_s;
  logic          ready_r, err_zero_r, mem_rd_r, mac_rst_r, rescale_r, done_valid_r;
  logic          mac_en_s;

  // Next-state, address and phase-timer decode.
  always_comb begin
    state_nxt_s  = state_r;
    addr_nxt_s   = '0;
    k_last_nxt_s = k_last_r;
    tmr_nxt_s    = tmr_r;
    accept_s     = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.k_len != '0) begin
            accept_s     = 1'b1;
            k_last_nxt_s = bus.k_len[AW-1:0] - ONE_AW;
            state_nxt_s  = ST_CLEAR;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_nxt_s = ST_ACCUM;
      end
      ST_ACCUM: begin
        // Compare against K-1 so K = 2**AW stops at all-ones without wrapping.
        if (addr_r == k_last_r) begin
          state_nxt_s = ST_DRAIN;
          tmr_nxt_s   = DRAIN_LOAD;
        end else begin
          addr_nxt_s = addr_r + ONE_AW;
        end
      end
      ST_DRAIN: begin
        if (tmr_r == 8'd0) begin
          state_nxt_s = ST_RESCALE;
          tmr_nxt_s   = RESCALE_LOAD;
        end else begin
          tmr_nxt_s = tmr_r - 8'd1;
        end
      end
      ST_RESCALE: begin
        if (tmr_r == 8'd0) begin
          if (QUANT_LAT == 0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_QWAIT;
            tmr_nxt_s   = QUANT_LOAD;
          end
        end else begin
          tmr_nxt_s = tmr_r - 8'd1;
        end
      end
      ST_QWAIT: begin
        if (tmr_r == 8'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          tmr_nxt_s = tmr_r - 8'd1;
        end
      end
      ST_DONE: begin
        if (bus.done_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered strobes decoded from the next state.
  always_ff @(posedge clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      k_last_r     <= '0;
      tmr_r        <= 8'd0;
      ready_r      <= 1'b1;
      err_zero_r   <= 1'b0;
      mem_rd_r     <= 1'b0;
      mac_rst_r    <= 1'b0;
      rescale_r    <= 1'b0;
      done_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      addr_r       <= addr_nxt_s;
      k_last_r     <= k_last_nxt_s;
      tmr_r        <= tmr_nxt_s;
      ready_r      <= (state_nxt_s == ST_IDLE);
      err_zero_r   <= err_s;
      mem_rd_r     <= (state_nxt_s == ST_ACCUM);
      mac_rst_r    <= (state_nxt_s == ST_CLEAR);
      rescale_r    <= (state_nxt_s == ST_RESCALE);
      done_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  generate
    if (MEM_LAT == 0) begin : g_en_direct
      assign mac_en_s = mem_rd_r;
    end else begin : g_en_pipe
      logic [MEM_LAT-1:0] en_pipe_r;

      // Delay the read strobe so accumulation lines up with RAM data.
      always_ff @(posedge clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
          en_pipe_r <= '0;
        end else begin
          en_pipe_r[0] <= mem_rd_r;
          for (int i = 1; i < MEM_LAT; i++) begin
            en_pipe_r[i] <= en_pipe_r[i-1];
          end
        end
      end

      assign mac_en_s = en_pipe_r[MEM_LAT-1];
    end
  endgenerate

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] perf_r;

  // Accept loads 1; stop counting once DONE is entered so the first DONE cycle holds the latency.
  always_ff @(posedge clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      perf_r <= 16'd0;
    end else if (accept_s) begin
      perf_r <= 16'd1;
    end else if ((state_r != ST_IDLE) && (state_r != ST_DONE) &&
                 (state_nxt_s != ST_DONE) && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.perf_cycles = perf_r;
`endif

  assign bus.ready      = ready_r;
  assign bus.err_zero   = err_zero_r;
  assign bus.mem_rd     = mem_rd_r;
  assign bus.mem_addr   = addr_r;
  assign bus.mac_rst    = mac_rst_r;
  assign bus.mac_en     = mac_en_s;
  assign bus.rescale    = rescale_r;
  assign bus.done_valid = done_valid_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: commands push expected passes, a monitor
// checks every cycle against a timeline built from the pass latency rules.
module tb_mac_seq_ctrl;
  localparam int AW = 8;
  localparam int ML = 1;
  localparam int AL = 1;
  localparam int RC = 2;
  localparam int QL = 4;

  typedef struct {
    int k;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic main_rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   in_rst;
  exp_t exp_q[$];
  int   err_q[$];

  mac_seq_if #(.AW(AW)) bus ();

  mac_seq_ctrl #(
    .AW(AW), .MEM_LAT(ML), .ACC_LAT(AL), .RESCALE_CYC(RC), .QUANT_LAT(QL)
  ) dut (
    .clk(clk),
    .main_rst_n(main_rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int k);
    return 1 + k + ML + AL + RC + QL;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic issue(input int k, output int acc);
    exp_t e;
    bus.start = 1'b1;
    bus.k_len = k[AW:0];
    acc   = cyc + 1;
    e.k   = k;
    e.acc = acc;
    exp_q.push_back(e);
    tick();
    bus.start = 1'b0;
    bus.k_len = 9'($urandom);
  endtask

  task automatic zero_cmd();
    bus.start = 1'b1;
    bus.k_len = '0;
    err_q.push_back(cyc + 1);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic finish_pass(input int acc, input int k, input int hold);
    wait_to(acc + lat_of(k) + hold);
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
  endtask

  // Monitor: expected outputs derived from where each cycle falls in the active pass.
  initial begin : monitor
    int p, k, lat;
    bit act, ex_err;
    logic [6:0] ex_v, got_v;
    int obs_rd, obs_en, obs_rs, obs_rst;
    obs_rd = 0; obs_en = 0; obs_rs = 0; obs_rst = 0;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        obs_rd = 0; obs_en = 0; obs_rs = 0; obs_rst = 0;
      end else begin
        act = (exp_q.size() > 0) && (cyc >= exp_q[0].acc);
        while (err_q.size() > 0 && err_q[0] < cyc) void'(err_q.pop_front());
        ex_err = (err_q.size() > 0) && (err_q[0] == cyc);
        if (ex_err) void'(err_q.pop_front());
        p = 0; k = 0; lat = 0;
        ex_v = {1'b1, 5'b00000, ex_err};
        if (act) begin
          k   = exp_q[0].k;
          p   = cyc - exp_q[0].acc;
          lat = lat_of(k);
          ex_v[6] = 1'b0;
          ex_v[5] = (p == 0);
          ex_v[4] = (p >= 1) && (p <= k);
          ex_v[3] = (p >= 1 + ML) && (p <= k + ML);
          ex_v[2] = (p >= 1 + k + ML + AL) && (p < 1 + k + ML + AL + RC);
          ex_v[1] = (p >= lat);
        end
        got_v = {bus.ready, bus.mac_rst, bus.mem_rd, bus.mac_en, bus.rescale,
                 bus.done_valid, bus.err_zero};
        chk("outputs{rdy,clr,rd,en,rs,dv,err}", 32'(got_v), 32'(ex_v));
        if (act && ex_v[4]) chk("mem_addr", 32'(bus.mem_addr), 32'(p - 1));
`ifdef MAC_SEQ_PERF_EN
        if (act && ex_v[1]) chk("perf_cycles", 32'(bus.perf_cycles), 32'(lat));
`endif
        if (act) begin
          obs_rd  += int'(bus.mem_rd);
          obs_en  += int'(bus.mac_en);
          obs_rs  += int'(bus.rescale);
          obs_rst += int'(bus.mac_rst);
          if (p >= lat && bus.done_valid === 1'b1 && bus.done_ready === 1'b1) begin
            chk("mem_rd_count", 32'(obs_rd), 32'(k));
            chk("mac_en_count", 32'(obs_en), 32'(k));
            chk("rescale_count", 32'(obs_rs), 32'(RC));
            chk("mac_rst_count", 32'(obs_rst), 32'd1);
            void'(exp_q.pop_front());
            obs_rd = 0; obs_en = 0; obs_rs = 0; obs_rst = 0;
          end
        end
      end
    end
  end

  initial begin : stim
    int acc, k;
    main_rst_n = 1'b0;
    in_rst = 1'b1;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.done_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_strobes", 32'({bus.mac_rst, bus.mem_rd, bus.mac_en, bus.rescale,
                              bus.done_valid, bus.err_zero}), 32'd0);
    #2 main_rst_n = 1'b1;
    tick();
    in_rst = 1'b0;
    tick();

    // K=28 with the consumer stalling completion for 10 cycles.
    issue(28, acc);
    finish_pass(acc, 28, 10);

    zero_cmd();
    tick();
    issue(1, acc);
    finish_pass(acc, 1, 0);

    // Full address range, must not wrap back to 0.
    issue(256, acc);
    finish_pass(acc, 256, 2);

    // Starts during ACCUM are ignored, including a zero-length one.
    issue(20, acc);
    wait_to(acc + 5);
    bus.start = 1'b1;
    bus.k_len = '0;
    tick();
    bus.k_len = 9'd9;
    tick();
    bus.start = 1'b0;
    finish_pass(acc, 20, 1);

    // Reset while addr=12 is on the bus, then a fresh short pass.
    issue(30, acc);
    wait_to(acc + 13);
    chk("abort_addr", 32'(bus.mem_addr), 32'd12);
    in_rst = 1'b1;
    main_rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({bus.mac_rst, bus.mem_rd, bus.mac_en, bus.rescale,
                              bus.done_valid, bus.err_zero}), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    tick();
    tick();
    main_rst_n = 1'b1;
    exp_q.delete();
    err_q.delete();
    tick();
    in_rst = 1'b0;
    issue(4, acc);
    finish_pass(acc, 4, 0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(3) == 0) zero_cmd();
      k = $urandom_range(64, 1);
      issue(k, acc);
      if (k > 8 && $urandom_range(1) == 1) begin
        wait_to(acc + 3);
        bus.start = 1'b1;
        bus.k_len = 9'($urandom_range(256, 0));
        tick();
        bus.start = 1'b0;
      end
      finish_pass(acc, k, $urandom_range(5));
    end

    repeat (3) tick();
    chk("pending_passes", 32'(exp_q.size()), 32'd0);
    chk("pending_errors", 32'(err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
